// File: rtl/event_packetizer.sv
// Frames DRS readout events into packets: SYNC, payload, count, CRC-16-CCITT, END.
// Registered valid/ready output; payload capped at MAX_WORDS with overflow discarded.
module event_packetizer #(
    parameter int          MAX_WORDS = 9216,
    parameter logic [15:0] SYNC_WORD = 16'hAAAA,
    parameter logic [15:0] END_WORD  = 16'h5555
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] s_data_i,
    input  logic        s_valid_i,
    input  logic        s_last_i,
    output logic        s_ready_o,
    output logic [15:0] m_data_o,
    output logic        m_valid_o,
    output logic        m_last_o,
    input  logic        m_ready_i,
    output logic        busy_o,
    output logic [31:0] pkt_count_o,
    output logic [15:0] trunc_count_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PAYLOAD = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_COUNT   = 3'd3;
    localparam logic [2:0] S_CRC     = 3'd4;
    localparam logic [2:0] S_TRAILER = 3'd5;

    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

    logic [2:0]  state;
    logic [15:0] crc;
    logic [15:0] count;
    logic        trunc;
    logic        adv;
    logic        s_hs;
    logic [15:0] count_nxt;

    // One full word through the CCITT polynomial, MSB first.
    function automatic logic [15:0] crc_word(input logic [15:0] c_in, input logic [15:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    assign adv       = !m_valid_o || m_ready_i;
    assign s_hs      = s_valid_i && s_ready_o;
    assign count_nxt = count + 16'd1;
    assign busy_o    = (state != S_IDLE) || m_valid_o;

    always_comb begin
        s_ready_o = 1'b0;
        case (state)
            S_PAYLOAD: s_ready_o = adv;
            S_DRAIN:   s_ready_o = 1'b1;
            default:   s_ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            m_data_o      <= 16'h0000;
            m_valid_o     <= 1'b0;
            m_last_o      <= 1'b0;
            crc           <= 16'hFFFF;
            count         <= 16'h0000;
            trunc         <= 1'b0;
            pkt_count_o   <= 32'h0;
            trunc_count_o <= 16'h0;
        end else begin
            if (m_valid_o && m_ready_i && m_last_o)
                pkt_count_o <= pkt_count_o + 32'd1;

            // Retire the current word by default; any load below overrides it.
            if (adv) begin
                m_valid_o <= 1'b0;
                m_last_o  <= 1'b0;
            end

            case (state)
                S_IDLE: if (s_valid_i && adv) begin
                    m_data_o  <= SYNC_WORD;
                    m_valid_o <= 1'b1;
                    crc       <= 16'hFFFF;
                    count     <= 16'h0000;
                    trunc     <= 1'b0;
                    state     <= S_PAYLOAD;
                end
                S_PAYLOAD: if (s_hs) begin
                    m_data_o  <= s_data_i;
                    m_valid_o <= 1'b1;
                    crc       <= crc_word(crc, s_data_i);
                    count     <= count_nxt;
                    if (s_last_i) begin
                        state <= S_COUNT;
                    end else if (count_nxt == MAX_W) begin
                        trunc <= 1'b1;
                        state <= S_DRAIN;
                        if (trunc_count_o != 16'hFFFF)
                            trunc_count_o <= trunc_count_o + 16'd1;
                    end
                end
                S_DRAIN: if (s_valid_i && s_last_i) state <= S_COUNT;
                S_COUNT: if (adv) begin
                    m_data_o  <= {trunc, count[14:0]};
                    m_valid_o <= 1'b1;
                    state     <= S_CRC;
                end
                S_CRC: if (adv) begin
                    m_data_o  <= crc;
                    m_valid_o <= 1'b1;
                    state     <= S_TRAILER;
                end
                S_TRAILER: if (adv) begin
                    m_data_o  <= END_WORD;
                    m_valid_o <= 1'b1;
                    m_last_o  <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_event_packetizer.sv
// Randomized bench for event_packetizer: two instances (default and MAX_WORDS=4)
// checked every cycle against a packet-level scoreboard, plus literal anchors.
module tb_event_packetizer;

    localparam int MAXW0 = 9216;
    localparam int MAXW1 = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [15:0] s_data  [2];
    logic        s_valid [2];
    logic        s_last  [2];
    logic        s_ready [2];
    logic [15:0] m_data  [2];
    logic        m_valid [2];
    logic        m_last  [2];
    logic        m_ready [2];
    logic        busy    [2];
    logic [31:0] pkt     [2];
    logic [15:0] trc     [2];

    event_packetizer #(.MAX_WORDS(MAXW0)) dut0 (
        .clock(clock), .reset(reset),
        .s_data_i(s_data[0]), .s_valid_i(s_valid[0]), .s_last_i(s_last[0]), .s_ready_o(s_ready[0]),
        .m_data_o(m_data[0]), .m_valid_o(m_valid[0]), .m_last_o(m_last[0]), .m_ready_i(m_ready[0]),
        .busy_o(busy[0]), .pkt_count_o(pkt[0]), .trunc_count_o(trc[0]));

    event_packetizer #(.MAX_WORDS(MAXW1)) dut1 (
        .clock(clock), .reset(reset),
        .s_data_i(s_data[1]), .s_valid_i(s_valid[1]), .s_last_i(s_last[1]), .s_ready_o(s_ready[1]),
        .m_data_o(m_data[1]), .m_valid_o(m_valid[1]), .m_last_o(m_last[1]), .m_ready_i(m_ready[1]),
        .busy_o(busy[1]), .pkt_count_o(pkt[1]), .trunc_count_o(trc[1]));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int maxw [2] = '{MAXW0, MAXW1};

    // Expected output words {last, data} per instance, plus a log of observed words.
    logic [16:0] expq  [2][0:8191];
    int          wp    [2] = '{0, 0};
    int          rp    [2] = '{0, 0};
    logic [15:0] log_d [2][0:2047];
    int          log_c [2][0:2047];
    int          log_n [2] = '{0, 0};

    int          mpkt  [2] = '{0, 0};
    int          mtrc  [2] = '{0, 0};
    int          acc_i [2] = '{0, 0};
    logic        hold  [2] = '{1'b0, 1'b0};
    logic [15:0] hd    [2];
    logic        hl    [2];
    logic        rst_d = 1'b0;
    logic        rmode [2] = '{1'b0, 1'b0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_crc(input logic [15:0] w [$], input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++)
            for (int b = 15; b >= 0; b--) begin
                fb = c[15] ^ w[k][b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        return c;
    endfunction

    task automatic push_word(input int u, input logic last, input logic [15:0] d);
        expq[u][wp[u] % 8192] = {last, d};
        wp[u]++;
    endtask

    task automatic push_packet(input int u, input logic [15:0] w [$]);
        int n, p;
        logic tr;
        n  = w.size();
        p  = (n > maxw[u]) ? maxw[u] : n;
        tr = (n > maxw[u]);
        push_word(u, 1'b0, 16'hAAAA);
        for (int k = 0; k < p; k++) push_word(u, 1'b0, w[k]);
        push_word(u, 1'b0, {tr, 15'(p)});
        push_word(u, 1'b0, ref_crc(w, p));
        push_word(u, 1'b1, 16'h5555);
    endtask

    task automatic send_event(input int u, input logic [15:0] w [$], input int abort_after, input bit gaps);
        int  n, budget, acc;
        bit  hs;
        n   = w.size();
        acc = 0;
        push_packet(u, w);
        for (int k = 0; k < n; k++) begin
            if (gaps && ($urandom % 4 == 0)) begin
                s_valid[u] = 1'b0;
                @(posedge clock); #1;
            end
            s_data[u]  = w[k];
            s_valid[u] = 1'b1;
            s_last[u]  = (k == n - 1);
            budget = 0;
            hs = 1'b0;
            while (!hs && budget < 1000) begin
                @(negedge clock);
                hs = s_ready[u];
                @(posedge clock); #1;
                budget++;
            end
            if (!hs) begin
                chk("input_accept_timeout", 32'd0, 32'd1);
                break;
            end
            acc++;
            if (acc == abort_after) break;
        end
        s_valid[u] = 1'b0;
        s_last[u]  = 1'b0;
    endtask

    task automatic wait_idle(input int u);
        int budget;
        bit done;
        budget = 0;
        done = 1'b0;
        while (!done && budget < 5000) begin
            @(negedge clock); #1;
            done = (rp[u] == wp[u]) && !m_valid[u];
            budget++;
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        for (int u = 0; u < 2; u++)
            m_ready[u] = rmode[u] ? ($urandom % 3 != 0) : 1'b1;
    end

    // Per-cycle compare against the scoreboard; values here settle for the next edge.
    always @(negedge clock) begin
        for (int u = 0; u < 2; u++) begin
            if (rst_d) begin
                chk("reset_out", {m_valid[u], m_last[u], m_data[u]}, 32'd0);
                chk("reset_busy_ready", {busy[u], s_ready[u]}, 32'd0);
                chk("reset_counters", pkt[u] | 32'(trc[u]), 32'd0);
            end else begin
                if (hold[u])
                    chk("stall_stable", {m_valid[u], m_last[u], m_data[u]}, {1'b1, hl[u], hd[u]});
                if (m_valid[u]) chk("busy_valid", 32'(busy[u]), 32'd1);
                else if (rp[u] == wp[u]) chk("busy_idle", 32'(busy[u]), 32'd0);
                chk("pkt_count", pkt[u], 32'(mpkt[u]));
                chk("trunc_count", 32'(trc[u]), 32'(mtrc[u]));
            end
            if (reset) begin
                rp[u] = 0; wp[u] = 0; mpkt[u] = 0; mtrc[u] = 0; acc_i[u] = 0; hold[u] = 1'b0;
            end else begin
                hold[u] = m_valid[u] && !m_ready[u];
                hd[u]   = m_data[u];
                hl[u]   = m_last[u];
                if (m_valid[u] && m_ready[u]) begin
                    if (rp[u] == wp[u]) begin
                        chk("spurious_word", {15'd1, m_last[u], m_data[u]}, 32'd0);
                    end else begin
                        chk("out_word", {m_last[u], m_data[u]}, 32'(expq[u][rp[u] % 8192]));
                        if (expq[u][rp[u] % 8192][16]) mpkt[u]++;
                        rp[u]++;
                    end
                    if (log_n[u] < 2048) begin
                        log_d[u][log_n[u]] = m_data[u];
                        log_c[u][log_n[u]] = cyc;
                        log_n[u]++;
                    end
                end
                if (s_valid[u] && s_ready[u]) begin
                    acc_i[u]++;
                    if (s_last[u]) acc_i[u] = 0;
                    else if (acc_i[u] == maxw[u] && mtrc[u] < 65535) mtrc[u]++;
                end
            end
        end
        rst_d = reset;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ev [$];
        int p0;
        for (int u = 0; u < 2; u++) begin
            s_data[u] = '0; s_valid[u] = 1'b0; s_last[u] = 1'b0; m_ready[u] = 1'b1;
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // One-word zero event: fixed packet on consecutive cycles.
        log_n[0] = 0;
        ev = {}; ev.push_back(16'h0000);
        send_event(0, ev, 0, 1'b0);
        wait_idle(0);
        chk("one_len", 32'(log_n[0]), 32'd5);
        chk("one_w0", 32'(log_d[0][0]), 32'hAAAA);
        chk("one_w1", 32'(log_d[0][1]), 32'h0000);
        chk("one_w2", 32'(log_d[0][2]), 32'h0001);
        chk("one_w3", 32'(log_d[0][3]), 32'h1D0F);
        chk("one_w4", 32'(log_d[0][4]), 32'h5555);
        for (int k = 1; k < 5; k++) chk("one_consec", 32'(log_c[0][k] - log_c[0][k-1]), 32'd1);
        chk("one_pkt", pkt[0], 32'd1);

        // 1024 incrementing words under random backpressure and input gaps.
        rmode[0] = 1'b1;
        log_n[0] = 0;
        ev = {};
        for (int k = 0; k < 1024; k++) ev.push_back(16'(k));
        send_event(0, ev, 0, 1'b1);
        wait_idle(0);
        rmode[0] = 1'b0;
        chk("long_len", 32'(log_n[0]), 32'd1028);
        chk("long_count", 32'(log_d[0][1025]), 32'h0400);
        chk("long_crc", 32'(log_d[0][1026]), 32'(ref_crc(ev, 1024)));

        // Truncation: 10 words into MAX_WORDS=4.
        log_n[1] = 0;
        ev = {};
        for (int k = 0; k < 10; k++) ev.push_back(16'($urandom));
        send_event(1, ev, 0, 1'b0);
        wait_idle(1);
        chk("trunc_len", 32'(log_n[1]), 32'd8);
        chk("trunc_count_word", 32'(log_d[1][5]), 32'h8004);
        chk("trunc_counter", 32'(trc[1]), 32'd1);

        // Exactly MAX_WORDS with last on the final word: not truncated.
        log_n[1] = 0;
        ev = {};
        for (int k = 0; k < 4; k++) ev.push_back(16'($urandom));
        send_event(1, ev, 0, 1'b0);
        wait_idle(1);
        chk("exact_count_word", 32'(log_d[1][5]), 32'h0004);
        chk("exact_trunc_counter", 32'(trc[1]), 32'd1);

        // Random events into the small instance with backpressure.
        rmode[1] = 1'b1;
        for (int e = 0; e < 12; e++) begin
            ev = {};
            for (int k = 0; k < int'($urandom_range(1, 8)); k++) ev.push_back(16'($urandom));
            send_event(1, ev, 0, 1'b1);
        end
        wait_idle(1);
        rmode[1] = 1'b0;

        // Back-to-back 3-word events with continuous ready: no idle gap.
        p0 = int'(pkt[0]);
        log_n[0] = 0;
        ev = {16'h1111, 16'h2222, 16'h3333};
        send_event(0, ev, 0, 1'b0);
        ev = {16'h4444, 16'h5555, 16'h6666};
        send_event(0, ev, 0, 1'b0);
        wait_idle(0);
        chk("b2b_len", 32'(log_n[0]), 32'd14);
        chk("b2b_end", 32'(log_d[0][6]), 32'h5555);
        chk("b2b_sync", 32'(log_d[0][7]), 32'hAAAA);
        for (int k = 1; k < 14; k++) chk("b2b_consec", 32'(log_c[0][k] - log_c[0][k-1]), 32'd1);
        chk("b2b_pkt", pkt[0], 32'(p0 + 2));

        // Reset in the middle of a payload, then a clean packet.
        ev = {};
        for (int k = 0; k < 10; k++) ev.push_back(16'(16'h0100 + k));
        send_event(0, ev, 5, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_valid", 32'(m_valid[0]), 32'd0);
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
        log_n[0] = 0;
        ev = {16'hBEEF, 16'h0000, 16'hFFFF};
        send_event(0, ev, 0, 1'b0);
        wait_idle(0);
        chk("post_rst_len", 32'(log_n[0]), 32'd7);
        chk("post_rst_count", 32'(log_d[0][4]), 32'h0003);
        chk("post_rst_pkt", pkt[0], 32'd1);

        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/event_packetizer.md
Name: event_packetizer

Overview:
- Downstream of the DRS control block; consumes the per-event 16-bit readout word stream (ADC samples plus DRS-generated event header words).
- Frames each event into a self-delimiting packet: sync word, payload, word count, CRC-16, end word.
- Output is a 16-bit valid/ready/last stream toward the transport (AXI-stream / UART / Ethernet).
- Enforces a maximum payload length and keeps packet and truncation counters for monitoring.

Parameters:
MAX_WORDS, 9216, maximum payload words per packet (9 channels x 1024 samples); legal range 1..32767
SYNC_WORD, 16'hAAAA, first word of every packet
END_WORD, 16'h5555, last word of every packet, flagged with m_last_o

Ports:
clock  input  1  system clock
reset  input  1  reset, synchronous, active-high
s_data_i  input  16  payload word from DRS readout
s_valid_i  input  1  s_data_i valid
s_last_i  input  1  final word of the current event
s_ready_o  output  1  packetizer accepts s_data_i this cycle
m_data_o  output  16  packet word
m_valid_o  output  1  m_data_o valid
m_last_o  output  1  m_data_o is END_WORD
m_ready_i  input  1  downstream accepts m_data_o
busy_o  output  1  packet in progress or output word pending
pkt_count_o  output  32  completed packets (END_WORD handshakes)
trunc_count_o  output  16  truncated packets

Behaviour:
- Reset: state IDLE; m_valid_o=0, m_last_o=0, m_data_o=0, s_ready_o=0, busy_o=0, counters=0, CRC=16'hFFFF, word count=0, trunc flag=0. Reset mid-packet abandons the packet; no partial END_WORD is emitted.
- Output register: m_data_o, m_valid_o and m_last_o are registered. adv = !m_valid_o || m_ready_i. A new word is loaded only when adv=1; otherwise the output holds stable (AXI rules; valid never drops without a handshake).
- s_ready_o is combinational: adv in PAYLOAD, 1 in DRAIN, 0 in all other states.
- IDLE: if s_valid_i && adv, load SYNC_WORD and go to PAYLOAD. CRC is set to 16'hFFFF, count=0, trunc=0. No input word is consumed in this cycle.
- PAYLOAD, on s_valid_i && s_ready_o:
  - Load s_data_i to the output, update CRC, count+1.
  - If s_last_i: go to COUNT.
  - Else if count+1 == MAX_WORDS: set trunc and go to DRAIN.
  - Else remain in PAYLOAD.
  - s_last_i takes priority when it coincides with reaching MAX_WORDS: not truncated.
- DRAIN: accept and discard input words (no CRC/count update) until a handshake with s_last_i=1, then go to COUNT.
- COUNT: on adv, load {trunc, count[14:0]} and go to CRC.
- CRC: on adv, load the CRC register and go to TRAILER.
- TRAILER: on adv, load END_WORD with m_last_o=1 and go to IDLE.
- Packet length: MAX_WORDS limits the payload, so a packet is at most MAX_WORDS+4 words.
- Back-to-back packets: a new SYNC_WORD may be loaded in the cycle after END_WORD is loaded. There are no idle cycles with continuous m_ready_i.
- CRC definition:
  - CRC-16-CCITT, poly 0x1021, init 0xFFFF, no reflection, no final XOR.
  - Computed over payload words only, 16 bits per word, MSB first, in a single cycle (unrolled).
- pkt_count_o increments on m_valid_o && m_ready_i && m_last_o; it wraps at 2^32.
- trunc_count_o increments on the PAYLOAD->DRAIN transition and saturates at 16'hFFFF.
- busy_o = (state != IDLE) || m_valid_o.
- Throughput: 1 payload word per clock with m_ready_i held high. Latency from input handshake to m_valid_o is 1 cycle.

Test Plan:
- One-word event 16'h0000 with s_last_i, m_ready_i=1 -> output AAAA, 0000, 0001, 1D0F, 5555 (last=1) on consecutive cycles; pkt_count_o=1.
- Event of 1024 incrementing words, m_ready_i toggling pseudo-randomly -> no word lost or duplicated; count word 16'h0400; CRC matches the reference model; m_data_o stable while stalled.
- MAX_WORDS=4, 10-word event -> payload holds the first 4 words; the remaining 6 are accepted (s_ready_o=1) and dropped; count word 16'h8004; trunc_count_o=1.
- MAX_WORDS=4, exactly 4-word event with s_last_i on word 4 -> count word 16'h0004; trunc_count_o unchanged.
- Two back-to-back 3-word events with continuous ready -> second AAAA immediately follows the first 5555; pkt_count_o=2.
- Reset asserted while in PAYLOAD after 5 words -> next cycle m_valid_o=0, busy_o=0; the following event produces a complete correct packet.
